// File: rtl/apb4_param_regbank.sv
// rtl/apb4_param_regbank.sv - parametrised APB4 register bank with RW config, W1C status, IRQ enables
//
// Address map (byte addresses):
//   0x000           RO ID register
//   0x100 + 4*i     RW config register i   (i < NUM_RW)
//   0x200 + 4*j     W1C status register j  (j < NUM_STS)
//   0x300 + 4*j     RW IRQ enable for status register j
//
// Ports:
//   clk, rst_b                          clock, async active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb, pprot                APB4 requester side
//   prdata, pready, pslverr             APB4 completer response
//   cfg_rw, rw_wr_pulse                 config register values and post-write pulses
//   sts_set, sts_val                    HW status set pulses and current status values
//   irq                                 registered OR of enabled status bits
module apb4_param_regbank #(
    parameter int          ADDR_W   = 12,
    parameter int          DATA_W   = 32,
    parameter int          NUM_RW   = 4,
    parameter int          NUM_STS  = 2,
    parameter int          WAIT_CYC = 0,
    parameter logic [31:0] ID_VAL   = 32'h0001_0002,
    parameter logic [31:0] RW_RST   = 32'h0000_0000,
    parameter bit          PRIV_WR  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [3:0]            pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [NUM_RW*32-1:0]  cfg_rw,
    output logic [NUM_RW-1:0]     rw_wr_pulse,
    input  logic [NUM_STS*32-1:0] sts_set,
    output logic [NUM_STS*32-1:0] sts_val,
    output logic                  irq
);

    localparam int PW = ADDR_W - 8;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic [ADDR_W-1:0]      addr_q;
    logic                   wr_q;
    logic                   prot_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [3:0]             strb_q;
    logic [NUM_STS*32-1:0]  en_q;
    logic [NUM_STS*32-1:0]  sts_w1c;
    logic                   setup;
    logic                   waiting;
    logic                   err_c;
    logic                   commit;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic [DATA_W-1:0]      wmask;
    logic [PW-1:0]          page_q;
    logic [6:0]             idx_q;
    logic                   unused_prot;

    // Only pprot[0] (privileged) matters to this block.
    assign unused_prot = ^pprot[2:1];

    function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic wr, input logic prot0);
        logic [PW-1:0] page;
        logic [6:0]    idx;
        logic          bad;
        page = a[ADDR_W-1:8];
        idx  = {1'b0, a[7:2]};
        bad  = (a[1:0] != 2'b00);
        if (page == PW'(0))
            bad = bad | (idx != 7'd0) | wr;
        else if (page == PW'(1))
            bad = bad | (idx >= 7'(NUM_RW));
        else if (page == PW'(2) || page == PW'(3))
            bad = bad | (idx >= 7'(NUM_STS));
        else
            bad = 1'b1;
        if (PRIV_WR && wr && !prot0)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    assign setup   = (state == IDLE) && psel && !penable;
    assign waiting = (state == ACCESS) && psel && (cnt != 4'd0);
    assign page_q  = addr_q[ADDR_W-1:8];
    assign idx_q   = {1'b0, addr_q[7:2]};
    assign wmask   = strb_mask(strb_q);

    // Response is decoded purely from registered state; no APB input reaches pready/pslverr.
    assign err_c   = addr_err(addr_q, wr_q, prot_q);
    assign pready  = (state == ACCESS) && (cnt == 4'd0);
    assign pslverr = pready && err_c;
    assign commit  = pready && psel && wr_q && !err_c;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 4'(WAIT_CYC);
                end
            end
            ACCESS: begin
                if (!psel)
                    state_nxt = IDLE;
                else if (cnt != 4'd0)
                    cnt_nxt = cnt - 4'd1;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux looks at the live bus address during setup and the latched one during waits.
    always_comb begin
        rd_addr = (state == IDLE) ? paddr : addr_q;
        rd_data = '0;
        if (!addr_err(rd_addr, 1'b0, 1'b1)) begin
            if (rd_addr[ADDR_W-1:8] == PW'(0))
                rd_data = ID_VAL;
            for (int i = 0; i < NUM_RW; i++)
                if (rd_addr[ADDR_W-1:8] == PW'(1) && rd_addr[7:2] == 6'(i))
                    rd_data = cfg_rw[32*i +: 32];
            for (int j = 0; j < NUM_STS; j++) begin
                if (rd_addr[ADDR_W-1:8] == PW'(2) && rd_addr[7:2] == 6'(j))
                    rd_data = sts_val[32*j +: 32];
                if (rd_addr[ADDR_W-1:8] == PW'(3) && rd_addr[7:2] == 6'(j))
                    rd_data = en_q[32*j +: 32];
            end
        end
    end

    always_comb begin
        sts_w1c = '0;
        for (int j = 0; j < NUM_STS; j++)
            if (commit && page_q == PW'(2) && idx_q == 7'(j))
                sts_w1c[32*j +: 32] = wdata_q & wmask;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            prot_q  <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prdata  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (setup) begin
                addr_q  <= paddr;
                wr_q    <= pwrite;
                prot_q  <= pprot[0];
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            if (setup || waiting)
                prdata <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cfg_rw      <= {NUM_RW{RW_RST}};
            rw_wr_pulse <= '0;
            sts_val     <= '0;
            en_q        <= '0;
            irq         <= 1'b0;
        end else begin
            rw_wr_pulse <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (commit && page_q == PW'(1) && idx_q == 7'(i)) begin
                    cfg_rw[32*i +: 32] <= (cfg_rw[32*i +: 32] & ~wmask) | (wdata_q & wmask);
                    rw_wr_pulse[i]     <= 1'b1;
                end
            end
            for (int j = 0; j < NUM_STS; j++) begin
                if (commit && page_q == PW'(3) && idx_q == 7'(j))
                    en_q[32*j +: 32] <= (en_q[32*j +: 32] & ~wmask) | (wdata_q & wmask);
            end
            // HW set is OR-ed in after the clear so a coincident set wins.
            sts_val <= (sts_val & ~sts_w1c) | sts_set;
            irq     <= |(sts_val & en_q);
        end
    end

endmodule

// File: tb/tb_apb4_param_regbank.sv
// tb/tb_apb4_param_regbank.sv - directed self-checking bench for apb4_param_regbank
module tb_apb4_param_regbank;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          psel0 = 1'b0;
    logic          psel1 = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [11:0]   paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [2:0]    pprot = '0;
    logic [63:0]   sts_set0 = '0;
    logic [63:0]   sts_set1 = '0;

    logic [31:0]   prdata0, prdata1;
    logic          pready0, pready1, pslverr0, pslverr1, irq0, irq1;
    logic [127:0]  cfg_rw0, cfg_rw1;
    logic [3:0]    rw_wr_pulse0, rw_wr_pulse1;
    logic [63:0]   sts_val0, sts_val1;

    int total = 0;
    int bad = 0;

    apb4_param_regbank dut0 (
        .clk(clk), .rst_b(rst_b), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .cfg_rw(cfg_rw0), .rw_wr_pulse(rw_wr_pulse0),
        .sts_set(sts_set0), .sts_val(sts_val0), .irq(irq0)
    );

    apb4_param_regbank #(.WAIT_CYC(3), .PRIV_WR(1'b1)) dut1 (
        .clk(clk), .rst_b(rst_b), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
        .cfg_rw(cfg_rw1), .rw_wr_pulse(rw_wr_pulse1),
        .sts_set(sts_set1), .sts_val(sts_val1), .irq(irq1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full APB transfer; set0 is driven onto sts_set0 so it lands on the commit edge.
    task automatic xfer(input bit which, input bit wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] prot,
                        input logic [31:0] set0,
                        output logic [31:0] rd, output logic err, output int waits);
        @(negedge clk);
        if (which) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = prot;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (((which ? pready1 : pready0) !== 1'b1) && waits < 32) begin
            @(negedge clk);
            waits++;
        end
        chk("xfer_no_timeout", 32'(waits < 32), 32'd1);
        rd  = which ? prdata1 : prdata0;
        err = which ? pslverr1 : pslverr0;
        sts_set0 = {32'h0, set0};
        @(negedge clk);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; sts_set0 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;

        repeat (2) @(negedge clk);
        chk("rst_prdata", prdata0, 32'h0);
        chk("rst_pready", pready0, 32'h0);
        chk("rst_pslverr", pslverr0, 32'h0);
        chk("rst_irq", irq0, 32'h0);
        chk("rst_cfg1", cfg_rw0[63:32], 32'h0);
        chk("rst_sts0", sts_val0[31:0], 32'h0);
        chk("rst_pulse", 32'(rw_wr_pulse0), 32'h0);
        rst_b = 1'b1;

        // ID read, zero wait states
        xfer(0, 0, 12'h000, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("id_waits", 32'(w), 32'd0);
        chk("id_data", rd, 32'h0001_0002);
        chk("id_err", er, 32'h0);

        // Byte-strobe write to RW reg 1
        xfer(0, 1, 12'h104, 32'hAABB_CCDD, 4'b0101, 3'b000, 32'h0, rd, er, w);
        chk("rw1_err", er, 32'h0);
        chk("rw1_val", cfg_rw0[63:32], 32'h00BB_00DD);
        chk("rw1_pulse", 32'(rw_wr_pulse0), 32'h2);
        @(negedge clk);
        chk("rw1_pulse_gone", 32'(rw_wr_pulse0), 32'h0);
        xfer(0, 0, 12'h104, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("rw1_readback", rd, 32'h00BB_00DD);

        // Zero strobes: no change, pulse still fires
        xfer(0, 1, 12'h104, 32'hFFFF_FFFF, 4'b0000, 3'b000, 32'h0, rd, er, w);
        chk("strb0_err", er, 32'h0);
        chk("strb0_val", cfg_rw0[63:32], 32'h00BB_00DD);
        chk("strb0_pulse", 32'(rw_wr_pulse0), 32'h2);

        // Status / IRQ
        xfer(0, 1, 12'h300, 32'h0000_0004, 4'hF, 3'b000, 32'h0, rd, er, w);
        chk("en0_err", er, 32'h0);
        @(negedge clk);
        sts_set0 = 64'h5;
        @(negedge clk);
        sts_set0 = '0;
        chk("sts_set", sts_val0[31:0], 32'h5);
        chk("irq_lag", irq0, 32'h0);
        @(negedge clk);
        chk("irq_on", irq0, 32'h1);
        xfer(0, 1, 12'h200, 32'h0000_0004, 4'hF, 3'b000, 32'h0, rd, er, w);
        chk("w1c_val", sts_val0[31:0], 32'h1);
        @(negedge clk);
        chk("irq_off", irq0, 32'h0);
        xfer(0, 0, 12'h200, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("sts_read", rd, 32'h1);
        chk("sts_read_noclr", sts_val0[31:0], 32'h1);
        xfer(0, 1, 12'h200, 32'h0000_0001, 4'hF, 3'b000, 32'h1, rd, er, w);
        chk("set_wins", sts_val0[31:0], 32'h1);
        xfer(0, 1, 12'h200, 32'h0000_0001, 4'hF, 3'b000, 32'h0, rd, er, w);
        chk("w1c_bit0", sts_val0[31:0], 32'h0);

        // Error cases
        xfer(0, 0, 12'h102, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("unalign_err", er, 32'h1);
        chk("unalign_data", rd, 32'h0);
        xfer(0, 0, 12'h110, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("rw_oob_err", er, 32'h1);
        chk("rw_oob_data", rd, 32'h0);
        xfer(0, 1, 12'h110, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, rd, er, w);
        chk("rw_oob_wr_err", er, 32'h1);
        chk("rw_oob_wr_pulse", 32'(rw_wr_pulse0), 32'h0);
        chk("rw_oob_reg1", cfg_rw0[63:32], 32'h00BB_00DD);
        chk("rw_oob_reg3", cfg_rw0[127:96], 32'h0);
        xfer(0, 1, 12'h000, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, rd, er, w);
        chk("id_wr_err", er, 32'h1);
        xfer(0, 0, 12'h000, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("id_unchanged", rd, 32'h0001_0002);
        xfer(0, 0, 12'h208, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("sts_oob_err", er, 32'h1);
        xfer(0, 0, 12'h400, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("hole_err", er, 32'h1);

        // Wait states and privilege on dut1
        xfer(1, 0, 12'h000, 32'h0, 4'h0, 3'b000, 32'h0, rd, er, w);
        chk("wait_count", 32'(w), 32'd3);
        chk("wait_id", rd, 32'h0001_0002);
        xfer(1, 1, 12'h100, 32'h1122_3344, 4'hF, 3'b001, 32'h0, rd, er, w);
        chk("priv_ok_err", er, 32'h0);
        chk("priv_ok_val", cfg_rw1[31:0], 32'h1122_3344);
        xfer(1, 1, 12'h100, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, rd, er, w);
        chk("priv_rej_err", er, 32'h1);
        chk("priv_rej_val", cfg_rw1[31:0], 32'h1122_3344);

        // Abort: psel dropped during a wait cycle
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h108;
        pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b001;
        @(negedge clk);
        penable = 1'b1;
        chk("abort_wait_pready", pready1, 32'h0);
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_pready", pready1, 32'h0);
            chk("abort_pulse", 32'(rw_wr_pulse1), 32'h0);
        end
        chk("abort_val", cfg_rw1[95:64], 32'h0);

        // Reset in the middle of an access
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h104;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pprot = 3'b001;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("mrst_pready", pready1, 32'h0);
        chk("mrst_pslverr", pslverr1, 32'h0);
        chk("mrst_prdata", prdata1, 32'h0);
        chk("mrst_cfg0", cfg_rw1[31:0], 32'h0);
        chk("mrst_cfg1", cfg_rw1[63:32], 32'h0);
        chk("mrst_irq", irq1, 32'h0);
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("mrst_pulse", 32'(rw_wr_pulse1), 32'h0);
        rst_b = 1'b1;
        xfer(1, 0, 12'h104, 32'h0, 4'h0, 3'b001, 32'h0, rd, er, w);
        chk("post_rst_read", rd, 32'h0);
        chk("post_rst_waits", 32'(w), 32'd3);
        xfer(1, 1, 12'h104, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0, rd, er, w);
        chk("post_rst_wr_err", er, 32'h0);
        chk("post_rst_wr_val", cfg_rw1[63:32], 32'hCAFE_F00D);
        chk("post_rst_pulse", 32'(rw_wr_pulse1), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
